// File: rtl/uriscv_ahb_pkg.sv
// Shared AHB-Lite constants, master FSM state type and strobe decode for the
// uriscv two-requester AHB arbiter.
package uriscv_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } ahb_state_e;

  // Reads present an all-zero strobe and fall through to a word access.
  function automatic logic [2:0] strb_to_hsize(input logic [3:0] strb);
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: strb_to_hsize = HSIZE_BYTE;
      4'b0011, 4'b1100:                   strb_to_hsize = HSIZE_HALF;
      default:                            strb_to_hsize = HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/uriscv_rr_arb2.sv
// Two-way grant: round-robin on the last winner, or fixed priority to
// requester 0 when RR_EN is clear.
module uriscv_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // last_q = 1 means requester 1 won most recently, so requester 0 wins first.
  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (RR_EN && !last_q) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (update_i && |gnt_o) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/uriscv_ahb_arb.sv
// Two-requester AHB-Lite master: arbitrates, then runs one SINGLE transfer at
// a time through IDLE -> ADDR -> DATA.
module uriscv_ahb_arb
  import uriscv_ahb_pkg::*;
#(
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned ERR_ACK = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        m0_rd_i,
  input  logic [3:0]  m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_rd_i,
  input  logic [3:0]  m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready_in,
  input  logic        hresp
);

  ahb_state_e  state_q, state_d;
  logic [1:0]  req_vld, gnt;
  logic        start, done, ack_vld, err_flag, rdata_cap;
  logic        own_q, wr_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q, rd_now;
  logic [3:0]  sel_wr;
  logic [31:0] sel_addr, sel_addr_al, sel_wdata;
  logic [2:0]  sel_size;

  assign req_vld = {m1_rd_i | (|m1_wr_i), m0_rd_i | (|m0_wr_i)};
  assign start   = (state_q == ST_IDLE) && (|req_vld) && !hreset;

  uriscv_rr_arb2 #(.RR_EN(RR_EN != 0)) u_arb (
    .clk_i    (hclk),
    .rst_i    (hreset),
    .req_i    (req_vld),
    .update_i (start),
    .gnt_o    (gnt)
  );

  assign sel_wr    = gnt[1] ? m1_wr_i    : m0_wr_i;
  assign sel_addr  = gnt[1] ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = gnt[1] ? m1_wdata_i : m0_wdata_i;
  assign sel_size  = strb_to_hsize(sel_wr);

  always_comb begin
    sel_addr_al = sel_addr;
    case (sel_size)
      HSIZE_HALF: sel_addr_al[0]   = 1'b0;
      HSIZE_WORD: sel_addr_al[1:0] = 2'b00;
      default:    ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (|req_vld) state_d = ST_ADDR;
      ST_ADDR: if (hready_in) state_d = ST_DATA;
      ST_DATA: begin
        if (hready_in) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion outputs are gated by reset so an in-flight transfer never acks.
  assign ack_vld   = done && !hreset;
  assign err_flag  = (ERR_ACK != 0) && hresp;
  assign rd_now    = (hresp && ERR_ACK == 0) ? '0 : hrdata;
  assign rdata_cap = ack_vld && !wr_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      own_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= HSIZE_WORD;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        own_q   <= gnt[1];
        wr_q    <= |sel_wr;
        size_q  <= sel_size;
        addr_q  <= sel_addr_al;
        wdata_q <= sel_wdata;
      end
      if (rdata_cap && !own_q) rdata0_q <= rd_now;
      if (rdata_cap &&  own_q) rdata1_q <= rd_now;
    end
  end

  assign m0_accept_o = start && gnt[0];
  assign m1_accept_o = start && gnt[1];
  assign m0_ack_o    = ack_vld && !own_q;
  assign m1_ack_o    = ack_vld &&  own_q;
  assign m0_err_o    = m0_ack_o && err_flag;
  assign m1_err_o    = m1_ack_o && err_flag;
  assign m0_rdata_o  = (rdata_cap && !own_q) ? rd_now : rdata0_q;
  assign m1_rdata_o  = (rdata_cap &&  own_q) ? rd_now : rdata1_q;

  assign htrans = (state_q == ST_ADDR && !hreset) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize  = size_q;
  assign hburst = HBURST_SINGLE;
  assign hwrite = wr_q;
  assign haddr  = addr_q;
  assign hwdata = wdata_q;

endmodule

// File: tb/tb_uriscv_ahb_arb.sv
// Bench for uriscv_ahb_arb: a round-robin/ERR_ACK=1 instance and a fixed
// priority/ERR_ACK=0 instance share directed stimulus and a transaction model.
module tb_uriscv_ahb_arb;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hreset;
  logic [1:0]  rd;
  logic [3:0]  wr[2];
  logic [31:0] addr[2], wdata[2];
  logic [31:0] hrdata;
  logic        hready, hresp;

  wire [1:0]  acc[2], ack[2], err[2];
  wire [31:0] rdo[2][2];
  wire [1:0]  htr[2];
  wire [2:0]  hsz[2], hbu[2];
  wire        hwr[2];
  wire [31:0] had[2], hwd[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    uriscv_ahb_arb #(.RR_EN(k == 0 ? 1 : 0), .ERR_ACK(k == 0 ? 1 : 0)) u (
      .hclk(hclk), .hreset(hreset),
      .m0_rd_i(rd[0]), .m0_wr_i(wr[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
      .m0_accept_o(acc[k][0]), .m0_ack_o(ack[k][0]), .m0_err_o(err[k][0]), .m0_rdata_o(rdo[k][0]),
      .m1_rd_i(rd[1]), .m1_wr_i(wr[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
      .m1_accept_o(acc[k][1]), .m1_ack_o(ack[k][1]), .m1_err_o(err[k][1]), .m1_rdata_o(rdo[k][1]),
      .htrans(htr[k]), .hsize(hsz[k]), .hburst(hbu[k]), .hwrite(hwr[k]),
      .haddr(had[k]), .hwdata(hwd[k]),
      .hrdata(hrdata), .hready_in(hready), .hresp(hresp)
    );
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [3:0] s);
    if ($countones(s) == 1) return 3'd0;
    if (s == 4'b0011 || s == 4'b1100) return 3'd1;
    return 3'd2;
  endfunction

  // Transaction model: one transfer in flight, address phase then data phase.
  bit          busy[2]  = '{0, 0};
  bit          adone[2] = '{0, 0};
  bit          own[2]   = '{0, 0};
  bit          iswr[2]  = '{0, 0};
  bit          lastg[2] = '{1, 1};
  logic [31:0] m_addr[2] = '{0, 0};
  logic [31:0] m_wd[2]   = '{0, 0};
  logic [2:0]  m_size[2] = '{2, 2};
  logic [31:0] hold[2][2] = '{'{0, 0}, '{0, 0}};

  always @(negedge hclk) begin : cmp
    logic [1:0]  e_acc, e_ack, e_err;
    logic [31:0] e_rd[2];
    logic [1:0]  e_htr;
    bit          v0, v1, win;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        e_acc = 0; e_ack = 0; e_err = 0; e_htr = 0;
        e_rd[0] = hold[k][0]; e_rd[1] = hold[k][1];
        v0 = rd[0] || (wr[0] != 0);
        v1 = rd[1] || (wr[1] != 0);
        win = (v0 && v1) ? ((k == 0) ? !lastg[k] : 1'b0) : (v1 && !v0);
        if (!hreset) begin
          if (!busy[k]) begin
            if (v0 || v1) e_acc = win ? 2'b10 : 2'b01;
          end else if (!adone[k]) begin
            e_htr = 2;
          end else if (hready) begin
            e_ack[own[k]] = 1'b1;
            e_err[own[k]] = (k == 0) && hresp;
            if (!iswr[k]) e_rd[own[k]] = (hresp && k == 1) ? 32'd0 : hrdata;
          end
        end
        chk(k, "accept", acc[k], e_acc);
        chk(k, "ack", ack[k], e_ack);
        chk(k, "err", err[k], e_err);
        chk(k, "rdata0", rdo[k][0], e_rd[0]);
        chk(k, "rdata1", rdo[k][1], e_rd[1]);
        chk(k, "htrans", htr[k], e_htr);
        chk(k, "hsize", hsz[k], m_size[k]);
        chk(k, "hburst", hbu[k], 0);
        chk(k, "hwrite", hwr[k], iswr[k]);
        chk(k, "haddr", had[k], m_addr[k]);
        chk(k, "hwdata", hwd[k], m_wd[k]);
        // advance the model to what the next rising edge produces
        if (hreset) begin
          busy[k] = 0; adone[k] = 0; own[k] = 0; iswr[k] = 0; lastg[k] = 1;
          m_addr[k] = 0; m_wd[k] = 0; m_size[k] = 2; hold[k][0] = 0; hold[k][1] = 0;
        end else if (!busy[k]) begin
          if (v0 || v1) begin
            busy[k] = 1; adone[k] = 0; own[k] = win; lastg[k] = win;
            iswr[k] = (wr[win] != 0);
            m_size[k] = iswr[k] ? exp_size(wr[win]) : 3'd2;
            m_addr[k] = addr[win] & ~((32'd1 << m_size[k]) - 32'd1);
            m_wd[k] = wdata[win];
          end
        end else if (!adone[k]) begin
          if (hready) adone[k] = 1;
        end else if (hready) begin
          busy[k] = 0;
          hold[k][0] = e_rd[0]; hold[k][1] = e_rd[1];
        end
      end
    end
  end

  task automatic tick();
    @(posedge hclk); #1;
  endtask

  initial begin
    hreset = 1; rd = 0; hrdata = 0; hready = 1; hresp = 0;
    for (int n = 0; n < 2; n++) begin wr[n] = 0; addr[n] = 0; wdata[n] = 0; end
    tick(); chk_en = 1;
    tick(); tick();
    @(negedge hclk);
    chk(0, "rst_htrans", htr[0], 0); chk(0, "rst_hsize", hsz[0], 2); chk(0, "rst_haddr", had[0], 0);
    tick(); hreset = 0;
    tick();

    // m0 read, zero wait states
    rd[0] = 1; addr[0] = 32'h100; hrdata = 32'hDEADBEEF;
    @(negedge hclk); chk(0, "t1_accept", acc[0], 2'b01);
    tick(); rd[0] = 0;
    @(negedge hclk); chk(0, "t1_htrans", htr[0], 2); chk(0, "t1_haddr", had[0], 32'h100);
    tick();
    @(negedge hclk); chk(0, "t1_ack", ack[0], 2'b01); chk(0, "t1_rdata", rdo[0][0], 32'hDEADBEEF);
    tick();

    // m1 halfword write, misaligned address
    wr[1] = 4'b0011; addr[1] = 32'h203; wdata[1] = 32'h1234;
    @(negedge hclk); chk(0, "t2_accept", acc[0], 2'b10);
    tick(); wr[1] = 0;
    @(negedge hclk); chk(0, "t2_haddr", had[0], 32'h202); chk(0, "t2_hsize", hsz[0], 1);
    chk(0, "t2_hwrite", hwr[0], 1);
    tick();
    @(negedge hclk); chk(0, "t2_hwdata", hwd[0], 32'h1234); chk(0, "t2_ack", ack[0], 2'b10);
    tick();

    // continuous contention
    rd = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk(0, "t3_rr_grant", acc[0], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk(1, "t3_fp_grant", acc[1], 2'b01);
      tick(); tick();
      if (i == 3) rd = 0;
      tick();
    end

    // wait states: two in ADDR, three in DATA
    rd[0] = 1; addr[0] = 32'h40; hrdata = 32'hCAFEF00D;
    @(negedge hclk); chk(0, "t4_accept", acc[0], 2'b01);
    tick(); rd[0] = 0; hready = 0;
    @(negedge hclk); chk(0, "t4_htrans_stall", htr[0], 2);
    tick(); tick(); hready = 1;
    tick(); hready = 0;
    tick(); tick();
    @(negedge hclk); chk(0, "t4_no_ack_c6", ack[0], 0);
    tick(); hready = 1;
    @(negedge hclk); chk(0, "t4_ack_c7", ack[0], 2'b01); chk(0, "t4_rdata", rdo[0][0], 32'hCAFEF00D);
    tick();

    // two-cycle ERROR response on a read
    rd[0] = 1; addr[0] = 32'h80; hrdata = 32'h55AA55AA;
    tick(); rd[0] = 0;
    tick(); hready = 0; hresp = 1;
    @(negedge hclk); chk(0, "t5_first_err_ack", ack[0], 0); chk(0, "t5_first_err_err", err[0], 0);
    tick(); hready = 1;
    @(negedge hclk); chk(0, "t5_ack", ack[0], 2'b01); chk(0, "t5_err", err[0], 2'b01);
    chk(1, "t5_ack", ack[1], 2'b01); chk(1, "t5_err", err[1], 0); chk(1, "t5_rdata", rdo[1][0], 0);
    tick(); hresp = 0;

    // reset during DATA, then pointer back at its reset value
    wr[0] = 4'b0100; addr[0] = 32'h301; wdata[0] = 32'hA5;
    tick(); wr[0] = 0;
    tick(); hready = 0;
    tick(); hreset = 1; hready = 1;
    @(negedge hclk); chk(0, "t6_no_ack", ack[0], 0);
    tick();
    @(negedge hclk); chk(0, "t6_haddr", had[0], 0); chk(0, "t6_hwdata", hwd[0], 0);
    chk(0, "t6_hsize", hsz[0], 2);
    tick(); hreset = 0; rd = 2'b11; addr[0] = 32'h44; addr[1] = 32'h48;
    @(negedge hclk); chk(0, "t6_post_rst_grant", acc[0], 2'b01);
    tick(); rd[0] = 0;
    tick(); tick();
    @(negedge hclk); chk(0, "t6_pending_grant", acc[0], 2'b10);
    tick(); rd[1] = 0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uriscv_ahb_arb.md
URISCV_AHB_ARB -- requirements
Module: uriscv_ahb_arb

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority (m0 wins).
REQ-002 Parameter ERR_ACK, default 1, meaning: 1 = an AHB ERROR response still completes the transfer via ack with err set.
REQ-003 hclk  in  1  sole clock; all logic on rising edge.
REQ-004 hreset  in  1  reset, synchronous, active-high.
REQ-005 mN_rd_i  in  1  requester N read request, held until accepted (N = 0,1; applies to all mN_* ports).
REQ-006 mN_wr_i  in  4  requester N byte-lane write strobes; nonzero = write request.
REQ-007 mN_addr_i  in  32  requester N byte address.
REQ-008 mN_wdata_i  in  32  requester N write data.
REQ-009 mN_accept_o  out  1  one-cycle pulse: request captured.
REQ-010 mN_ack_o  out  1  one-cycle pulse: transfer complete.
REQ-011 mN_err_o  out  1  qualifies ack: AHB ERROR occurred.
REQ-012 mN_rdata_o  out  32  read data, valid with ack.
REQ-013 htrans  out  2  AHB-Lite transfer type (IDLE=0, NONSEQ=2 only).
REQ-014 hsize  out  3 ; hburst  out  3 (always SINGLE=0) ; hwrite  out  1 ; haddr  out  32 ; hwdata  out  32.
REQ-015 hrdata  in  32 ; hready_in  in  1 ; hresp  in  1 (0 OKAY, 1 ERROR).

Function
REQ-016 FSM states IDLE, ADDR, DATA; one outstanding transfer; no pipelining across transfers.
REQ-017 IDLE: if any request valid, arbitrate, latch winner's addr/wdata/strobes/index, pulse winner's accept, go to ADDR in the next cycle.
REQ-018 Request valid = mN_rd_i | (|mN_wr_i); if both rd and wr are asserted, the write takes precedence.
REQ-019 RR_EN=1: on contention, grant the requester not granted last; last-grant pointer resets to 1 (m0 wins first contention).
REQ-020 RR_EN=0: m0 always wins contention.
REQ-021 ADDR: htrans=NONSEQ, haddr/hwrite/hsize from latch; advance to DATA when hready_in=1, else hold all outputs stable.
REQ-022 DATA: htrans=IDLE, hwdata=latched wdata; wait for hready_in=1, then pulse ack for the owner, capture hrdata into mN_rdata_o (reads only), and go to IDLE.
REQ-023 hsize encoding: strobes 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111 or read -> 2; any other strobe pattern -> 2.
REQ-024 haddr is driven with the low bits aligned to hsize (byte: as-is; half: [0]=0; word: [1:0]=0).
REQ-025 hresp=1 with hready_in=1 in DATA: ERR_ACK=1 gives ack and err pulsed together; ERR_ACK=0 gives ack with err=0 and rdata=0.
REQ-026 hresp=1 with hready_in=0 (first ERROR cycle) causes no action; wait for the second cycle.
REQ-027 Outside ADDR, htrans=IDLE; hwrite, haddr and hsize hold their last values.
REQ-028 accept and ack never pulse in the same cycle for the same requester; minimum transfer is 3 cycles IDLE->ADDR->DATA->IDLE with zero wait states.
REQ-029 The non-granted requester's request is left pending (not dropped) and is served at the next IDLE.

Reset
REQ-030 While hreset=1: state=IDLE, htrans=0, hsize=2, hburst=0, hwrite=0, haddr=0, hwdata=0, all accept/ack/err=0, rdata=0, RR pointer=1.
REQ-031 Reset asserted mid-transfer aborts the transfer with no ack issued.

Structure
REQ-032 Shared package uriscv_ahb_pkg holds: the htrans/hsize/hburst constants, the FSM state enum, and a strobe-to-hsize function.
REQ-033 One sub-module, uriscv_rr_arb2 (2-way round-robin/fixed grant with pointer), is instantiated once.

Verification
REQ-034 m0 read 0x100, zero wait states, hrdata=0xDEADBEEF -> accept at cycle 0, NONSEQ at cycle 1, m0 ack with rdata=0xDEADBEEF at cycle 2.
REQ-035 m1 write strobes 0011, addr 0x203, wdata 0x1234 -> haddr=0x202, hsize=1, hwrite=1, hwdata=0x1234 in DATA.
REQ-036 m0 and m1 both request continuously, RR_EN=1 -> grants m0,m1,m0,m1; with RR_EN=0 -> m0 served every time.
REQ-037 Two hready_in=0 cycles in ADDR and three in DATA -> outputs stable during the stalls, ack at exactly the seventh cycle after accept.
REQ-038 ERROR response (hresp=1 with hready_in=0, then hresp=1 with hready_in=1) -> ack=1 and err=1 in the second cycle only.
REQ-039 hreset pulsed during DATA -> no ack issued, all outputs return to reset values, next request served normally.
